// File: rtl/lat_release_queue_pkg.sv
// Shared constants for the latency release queue.
package lat_release_queue_pkg;

    localparam int LAT_W_DEFAULT = 4;

endpackage

// File: rtl/lat_slot.sv
// One queue entry: payload register, valid bit and a saturating hold counter
// that counts down to maturity.
module lat_slot
    import lat_release_queue_pkg::*;
#(
    parameter int DW = 32,
    parameter int LW = LAT_W_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          clear_i,
    input  logic          tick_i,
    input  logic [DW-1:0] data_i,
    input  logic [LW-1:0] lat_i,
    output logic          valid_o,
    output logic          mature_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q, valid_d;
    logic [LW-1:0] cnt_q,   cnt_d;
    logic [DW-1:0] data_q,  data_d;

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path can infer a latch.
        valid_d = valid_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        if (load_i) begin
            // A freshly loaded entry starts counting on the following cycle.
            valid_d = 1'b1;
            cnt_d   = lat_i;
            data_d  = data_i;
        end else begin
            if (clear_i) begin
                valid_d = 1'b0;
            end
            if (tick_i && valid_q && (cnt_q != '0)) begin
                cnt_d = cnt_q - LW'(1);
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every slot samples pre-edge values;
    // the payload register is reset too, keeping the head output defined from reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign valid_o  = valid_q;
    assign mature_o = valid_q && (cnt_q == '0);
    assign data_o   = data_q;

endmodule

// File: rtl/lat_release_queue.sv
// Elastic latency queue: holds each accepted transaction for its own number of
// cycles, then releases in strict FIFO order under valid/ready backpressure.
module lat_release_queue
    import lat_release_queue_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int LW    = LAT_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_data,
    input  logic [LW-1:0]            in_lat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic             acc_fire;
    logic             rel_fire;
    logic [DEPTH-1:0] slot_load;
    logic [DEPTH-1:0] slot_clear;
    logic [DEPTH-1:0] slot_valid;
    logic [DEPTH-1:0] slot_mature;
    logic [DW-1:0]    slot_data [DEPTH];

    // Full blocks acceptance even when a release is happening in the same cycle.
    assign in_ready  = !rst && (count_q != CW'(DEPTH));
    assign acc_fire  = in_valid && in_ready;

    assign out_valid = slot_mature[rd_ptr_q];
    assign out_data  = slot_valid[rd_ptr_q] ? slot_data[rd_ptr_q] : '0;
    assign rel_fire  = out_valid && out_ready;
    assign count     = count_q;

    always_comb begin
        slot_load             = '0;
        slot_clear            = '0;
        slot_load[wr_ptr_q]   = acc_fire;
        slot_clear[rd_ptr_q]  = rel_fire;
    end

    always_comb begin
        wr_ptr_d = acc_fire ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = rel_fire ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({acc_fire, rel_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Every slot matures independently of its position, so waiting entries
    // behind a slow head drain back-to-back once it leaves.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        lat_slot #(
            .DW (DW),
            .LW (LW)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load_i   (slot_load[g]),
            .clear_i  (slot_clear[g]),
            .tick_i   (1'b1),
            .data_i   (in_data),
            .lat_i    (in_lat),
            .valid_o  (slot_valid[g]),
            .mature_o (slot_mature[g]),
            .data_o   (slot_data[g])
        );
    end

endmodule

// File: tb/tb_lat_release_queue.sv
// Bench for lat_release_queue: a queue-of-deadlines model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_lat_release_queue;
    import lat_release_queue_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LW    = LAT_W_DEFAULT;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [LW-1:0] in_lat;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;

    lat_release_queue #(.DW(DW), .DEPTH(DEPTH), .LW(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_lat    (in_lat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: each held item carries the first cycle in which it may be released.
    typedef struct {
        logic [DW-1:0] data;
        longint        rdy;
    } item_t;

    item_t         mq[$];
    longint        cyc = 0;
    logic          acc_p = 1'b0;
    logic          rel_p = 1'b0;
    logic [DW-1:0] pd;
    logic [LW-1:0] pl;
    logic          prev_valid = 1'b0;
    logic          prev_rel   = 1'b0;

    always @(negedge clk) begin
        logic          exp_ready;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        exp_ready = !rst && (mq.size() != DEPTH);
        exp_valid = 1'b0;
        exp_data  = '0;
        if (mq.size() > 0) begin
            exp_data  = mq[0].data;
            exp_valid = (cyc >= mq[0].rdy);
        end
        check("m_in_ready",  64'(in_ready),  64'(exp_ready));
        check("m_out_valid", 64'(out_valid), 64'(exp_valid));
        check("m_out_data",  64'(out_data),  64'(exp_data));
        check("m_count",     64'(count),     64'(mq.size()));
        if (!rst && prev_valid && !prev_rel)
            check("m_valid_hold", 64'(out_valid), 64'd1);
        prev_valid = out_valid && !rst;
        prev_rel   = out_valid && out_ready;
        acc_p = !rst && in_valid && exp_ready;
        rel_p = !rst && exp_valid && out_ready;
        pd    = in_data;
        pl    = in_lat;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            acc_p = 1'b0;
            rel_p = 1'b0;
        end else begin
            if (rel_p) void'(mq.pop_front());
            if (acc_p) mq.push_back('{pd, cyc + 1 + longint'(pl)});
            cyc++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int sent;
        int guard;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_lat = '0; out_ready = 1'b0;

        at_sample();
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count",     64'(count),     64'd0);
        @(posedge clk); #2 rst = 1'b0;
        at_sample();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        next_cycle();

        // Single transaction, lat 3: released exactly 4 cycles after accept.
        in_valid = 1'b1; in_data = 32'hDEADBEEF; in_lat = 4'd3; out_ready = 1'b1;
        at_sample();
        check("t1_accept", 64'(in_ready), 64'd1);
        next_cycle();
        in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            at_sample();
            check("t1_wait", 64'(out_valid), 64'd0);
            next_cycle();
        end
        at_sample();
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_data",  64'(out_data),  64'hDEADBEEF);
        next_cycle();
        at_sample();
        check("t1_done_valid", 64'(out_valid), 64'd0);
        check("t1_done_count", 64'(count),     64'd0);
        next_cycle();

        // Zero-latency streaming: one item per cycle, no bubbles.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = DW'(i + 1); in_lat = '0;
            at_sample();
            if (i > 0) begin
                check("t2_valid", 64'(out_valid), 64'd1);
                check("t2_data",  64'(out_data),  64'(i));
                check("t2_count", 64'(count),     64'd1);
            end
            next_cycle();
        end
        in_valid = 1'b0;
        at_sample();
        check("t2_last_data", 64'(out_data), 64'd8);
        next_cycle();
        at_sample();
        check("t2_empty", 64'(out_valid), 64'd0);
        next_cycle();

        // Head-of-line blocking: A lat 6, then B lat 0.
        in_valid = 1'b1; in_data = 32'hA; in_lat = 4'd6;
        next_cycle();
        in_data = 32'hB; in_lat = 4'd0;
        at_sample();
        check("t3_c1_valid", 64'(out_valid), 64'd0);
        next_cycle();
        in_valid = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            at_sample();
            check("t3_blocked", 64'(out_valid), 64'd0);
            check("t3_count",   64'(count),     64'd2);
            next_cycle();
        end
        at_sample();
        check("t3_a_valid", 64'(out_valid), 64'd1);
        check("t3_a_data",  64'(out_data),  64'hA);
        next_cycle();
        at_sample();
        check("t3_b_valid", 64'(out_valid), 64'd1);
        check("t3_b_data",  64'(out_data),  64'hB);
        next_cycle();
        at_sample();
        check("t3_empty", 64'(out_valid), 64'd0);
        next_cycle();

        // Full and backpressure: five lat-0 items with out_ready low.
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 32'h100 + DW'(i); in_lat = '0;
            at_sample();
            check("t4_fill_ready", 64'(in_ready), 64'd1);
            next_cycle();
        end
        in_data = 32'h105;
        for (int c = 0; c < 3; c++) begin
            at_sample();
            check("t4_full_ready", 64'(in_ready),  64'd0);
            check("t4_full_count", 64'(count),     64'd4);
            check("t4_hold_valid", 64'(out_valid), 64'd1);
            check("t4_hold_data",  64'(out_data),  64'h101);
            next_cycle();
        end
        out_ready = 1'b1;
        at_sample();
        check("t4_rel_no_fallthrough", 64'(in_ready), 64'd0);
        check("t4_rel1_data", 64'(out_data), 64'h101);
        next_cycle();
        at_sample();
        check("t4_ready_back", 64'(in_ready), 64'd1);
        check("t4_rel2_data",  64'(out_data), 64'h102);
        next_cycle();
        in_valid = 1'b0;
        for (int i = 3; i <= 5; i++) begin
            at_sample();
            check("t4_drain_data", 64'(out_data), 64'h100 + 64'(i));
            next_cycle();
        end
        at_sample();
        check("t4_empty", 64'(out_valid), 64'd0);
        next_cycle();

        // Wrap-around: 20 items with random latency and random out_ready.
        sent = 0;
        guard = 0;
        while ((sent < 20 || count != 0) && guard < 3000) begin
            out_ready = (sent < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!in_valid && sent < 20) begin
                in_valid = 1'b1;
                in_data  = $urandom;
                in_lat   = LW'($urandom_range(0, 15));
            end
            at_sample();
            if (in_valid && in_ready) sent++;
            next_cycle();
            if (in_valid && in_ready) in_valid = 1'b0;
            guard++;
        end
        in_valid = 1'b0;
        check("t5_drained_in_budget", 64'(guard < 3000), 64'd1);
        check("t5_sent", 64'(sent), 64'd20);

        // Asynchronous reset with three immature items in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'hC0 + DW'(i); in_lat = 4'd15;
            next_cycle();
        end
        in_valid = 1'b0;
        at_sample();
        check("t6_held", 64'(count), 64'd3);
        #2 rst = 1'b1;
        #1;
        check("t6_async_valid", 64'(out_valid), 64'd0);
        check("t6_async_count", 64'(count),     64'd0);
        check("t6_async_ready", 64'(in_ready),  64'd0);
        @(posedge clk); #2 rst = 1'b0;
        at_sample();
        check("t6_release_ready", 64'(in_ready), 64'd1);
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            at_sample();
            check("t6_no_ghost", 64'(out_valid), 64'd0);
        end

        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
